// File: rtl/ddr_cmd_bus_arbiter.sv
// Round-robin, non-preemptive arbiter sharing the DDR4 fabric command bus, with a NOP gap between owners.
// Optional ARB_WATCHDOG_EN bounds ownership to MAX_HOLD cycles and raises a sticky timeout_err.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 17
`endif
`ifndef BANK_WIDTH
`define BANK_WIDTH 2
`endif
`ifndef BG_WIDTH
`define BG_WIDTH 2
`endif
`ifndef CS_WIDTH
`define CS_WIDTH 1
`endif
`ifndef CKE_WIDTH
`define CKE_WIDTH 1
`endif

module ddr_cmd_bus_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int GAP_CYCLES = 4,
   parameter int MAX_HOLD   = 4096
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ-1:0]                  done,
   output logic [NUM_REQ-1:0]                  gnt,
   output logic                                busy,
   output logic [2:0]                          owner,
   input  logic [NUM_REQ*8-1:0]                req_ACT_n,
   input  logic [NUM_REQ*`ADDR_WIDTH*8-1:0]    req_ADR,
   input  logic [NUM_REQ*`BANK_WIDTH*8-1:0]    req_BA,
   input  logic [NUM_REQ*`BG_WIDTH*8-1:0]      req_BG,
   input  logic [NUM_REQ*`CS_WIDTH*8-1:0]      req_CS_n,
   input  logic [NUM_REQ*`CKE_WIDTH*8-1:0]     req_CKE,
   output logic [7:0]                          mc_ACT_n,
   output logic [`ADDR_WIDTH*8-1:0]            mc_ADR,
   output logic [`BANK_WIDTH*8-1:0]            mc_BA,
   output logic [`BG_WIDTH*8-1:0]              mc_BG,
   output logic [`CS_WIDTH*8-1:0]              mc_CS_n,
   output logic [`CKE_WIDTH*8-1:0]             mc_CKE,
   output logic                                timeout_err,
   output logic [1:0]                          dbg_state
);
   localparam int AW  = `ADDR_WIDTH * 8;
   localparam int BAW = `BANK_WIDTH * 8;
   localparam int BGW = `BG_WIDTH * 8;
   localparam int CSW = `CS_WIDTH * 8;
   localparam int CKW = `CKE_WIDTH * 8;

   // Handshake: a source holds req high for as long as it wants the bus; ownership starts
   // when its gnt bit rises and ends on the cycle it pulses done or drops req.
   typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, GAP = 2'd2} state_t;

   state_t             state;
   logic [3:0]         gap_cnt;
   logic [2:0]         next_owner;
   logic               any_req;
   logic [2:0]         cand;
   logic [NUM_REQ-1:0] req_sh;
   logic [NUM_REQ-1:0] own_req_sh;
   logic [NUM_REQ-1:0] own_done_sh;
   logic               release_now;
   logic               wd_hit;

   assign dbg_state = state;

   // Round-robin search starting just after the last owner.
   always_comb begin
      next_owner = owner;
      any_req    = 1'b0;
      cand       = '0;
      req_sh     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand   = 3'((int'(owner) + i) % NUM_REQ);
         req_sh = req >> cand;
         if (!any_req && req_sh[0]) begin
            any_req    = 1'b1;
            next_owner = cand;
         end
      end
   end

   assign own_req_sh  = req >> owner;
   assign own_done_sh = done >> owner;
   assign release_now = own_done_sh[0] | ~own_req_sh[0] | wd_hit;

`ifdef ARB_WATCHDOG_EN
   logic [31:0] hold_cnt;

   assign wd_hit = (state == OWN) && (hold_cnt == 32'(MAX_HOLD - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         hold_cnt <= (state == OWN) ? hold_cnt + 32'd1 : '0;
         if (wd_hit) timeout_err <= 1'b1;
      end
   end
`else
   assign wd_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         busy     <= 1'b0;
         owner    <= 3'(NUM_REQ - 1);
         gap_cnt  <= '0;
         mc_ACT_n <= '1;
         mc_ADR   <= '1;
         mc_BA    <= '0;
         mc_BG    <= '0;
         mc_CS_n  <= '1;
         mc_CKE   <= '1;
      end else begin
         case (state)
            IDLE: begin
               mc_ACT_n <= '1;
               mc_ADR   <= '1;
               mc_BA    <= '0;
               mc_BG    <= '0;
               mc_CS_n  <= '1;
               if (any_req) begin
                  gnt   <= NUM_REQ'(1) << next_owner;
                  busy  <= 1'b1;
                  owner <= next_owner;
                  state <= OWN;
               end
            end
            OWN: begin
               mc_ACT_n <= req_ACT_n[int'(owner)*8 +: 8];
               mc_ADR   <= req_ADR[int'(owner)*AW +: AW];
               mc_BA    <= req_BA[int'(owner)*BAW +: BAW];
               mc_BG    <= req_BG[int'(owner)*BGW +: BGW];
               mc_CS_n  <= req_CS_n[int'(owner)*CSW +: CSW];
               // A watchdog release wakes the DRAM out of any self-refresh the owner left behind.
               mc_CKE   <= wd_hit ? '1 : req_CKE[int'(owner)*CKW +: CKW];
               if (release_now) begin
                  gnt  <= '0;
                  busy <= 1'b0;
                  if (GAP_CYCLES == 0) begin
                     state <= IDLE;
                  end else begin
                     state   <= GAP;
                     gap_cnt <= 4'(GAP_CYCLES);
                  end
               end
            end
            GAP: begin
               mc_ACT_n <= '1;
               mc_ADR   <= '1;
               mc_BA    <= '0;
               mc_BG    <= '0;
               mc_CS_n  <= '1;
               if (gap_cnt <= 4'd1) state <= IDLE;
               else gap_cnt <= gap_cnt - 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
